// File: rtl/ni_target_route_arbiter.sv
// ni_target_route_arbiter: round-robin sharing of one NI-target routing LUT with a one-entry route cache.
module ni_target_route_arbiter #(
  parameter int NREQ   = 4,
  parameter int SRC_W  = 4,
  parameter int PATH_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*SRC_W-1:0] req_addr,
  output logic [NREQ-1:0]       req_ready,
  output logic [SRC_W-1:0]      lut_address,
  input  logic [PATH_W-1:0]     lut_path,
  output logic [NREQ-1:0]       resp_valid,
  output logic [PATH_W-1:0]     resp_path,
  output logic                  resp_err,
  input  logic [NREQ-1:0]       resp_ready,
  input  logic                  flush
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;
  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_idx;
  logic [IW:0]         scan;
  logic                gnt_any, hit;
  logic [SRC_W-1:0]    g_addr, lut_addr_q, lut_addr_d, cache_addr_q, cache_addr_d;
  logic [PATH_W-1:0]   resp_path_q, resp_path_d, cache_path_q, cache_path_d;
  logic [NREQ-1:0]     resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d, cache_v_q, cache_v_d;
  // Scan downward so the valid index closest to rr_ptr is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      scan = (scan >= (IW+1)'(NREQ)) ? scan - (IW+1)'(NREQ) : scan;
      if (req_valid[scan[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IW-1:0];
      end
    end
  end
  assign g_addr    = req_addr[gnt_idx*SRC_W +: SRC_W];
  assign hit       = cache_v_q && (cache_addr_q == g_addr);
  assign req_ready = (state_q == IDLE && gnt_any) ? NREQ'(1) << gnt_idx : '0;
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    lut_addr_d   = lut_addr_q;
    resp_path_d  = resp_path_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = resp_valid_q;
    cache_v_d    = cache_v_q & ~flush;
    cache_addr_d = cache_addr_q;
    cache_path_d = cache_path_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        owner_d    = gnt_idx;
        lut_addr_d = g_addr;
        rr_ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        state_d    = hit ? RESP : LOOKUP;
        if (hit) begin
          resp_path_d  = cache_path_q;
          resp_err_d   = 1'b0;
          resp_valid_d = NREQ'(1) << gnt_idx;
        end
      end
      LOOKUP: begin
        resp_path_d  = lut_path;
        resp_err_d   = (lut_path == '0);
        resp_valid_d = NREQ'(1) << owner_q;
        state_d      = RESP;
        // Unknown sources are never cached; a coincident flush wins.
        if (lut_path != '0) begin
          cache_addr_d = lut_addr_q;
          cache_path_d = lut_path;
          cache_v_d    = ~flush;
        end
      end
      RESP: if (resp_ready[owner_q]) begin
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      lut_addr_q   <= '0;
      resp_path_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= '0;
      cache_v_q    <= 1'b0;
      cache_addr_q <= '0;
      cache_path_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      lut_addr_q   <= lut_addr_d;
      resp_path_q  <= resp_path_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      cache_v_q    <= cache_v_d;
      cache_addr_q <= cache_addr_d;
      cache_path_q <= cache_path_d;
    end
  end
  assign lut_address = lut_addr_q;
  assign resp_path   = resp_path_q;
  assign resp_err    = resp_err_q;
  assign resp_valid  = resp_valid_q;
endmodule

// File: tb/tb_ni_target_route_arbiter.sv
// tb_ni_target_route_arbiter: scoreboard bench with a transaction-level model of arbitration, cache and latency.
module tb_ni_target_route_arbiter;
  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  logic [3:0]  req_valid = '0, resp_ready = '1;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_ready, resp_valid, lut_address;
  logic [6:0]  lut_path, resp_path;
  logic        resp_err;
  logic [6:0]  tbl [16];

  always #5 clk = ~clk;
  assign lut_path = tbl[lut_address];

  ni_target_route_arbiter #(.NREQ(4), .SRC_W(4), .PATH_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .lut_address(lut_address), .lut_path(lut_path),
    .resp_valid(resp_valid), .resp_path(resp_path), .resp_err(resp_err),
    .resp_ready(resp_ready), .flush(flush)
  );

  typedef struct {int g; int addr; int path; int err; int lat; bit b2b;} exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0, cyc = 0, gcyc = 0, hcyc = 0, done = 0, stall_cnt = 0;
  int mrr = 0, mca = 0;
  bit mcv = 1'b0;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Reference model: round-robin pick, one-entry cache of the last good route.
  function automatic exp_t predict(input logic [3:0] m, input logic [15:0] a, input bit b2b);
    exp_t e;
    bit hit;
    e.g = 0;
    for (int k = 3; k >= 0; k--) if (m[2'((mrr + k) % 4)]) e.g = (mrr + k) % 4;
    e.addr = int'(a[e.g*4 +: 4]);
    e.path = int'(tbl[4'(e.addr)]);
    e.err  = (e.path == 0) ? 1 : 0;
    hit    = mcv && (mca == e.addr);
    e.lat  = hit ? 1 : 2;
    e.b2b  = b2b;
    if (!hit && e.path != 0) begin
      mcv = 1'b1;
      mca = e.addr;
    end
    mrr = (e.g + 1) % 4;
    return e;
  endfunction

  task automatic run(input logic [3:0] m, input logic [15:0] a, input int n, input int stall, input bit fl_lookup);
    int target, budget;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(predict(m, a, i > 0));
      if (fl_lookup) mcv = 1'b0;
    end
    target = done + n;
    stall_cnt = stall;
    @(posedge clk); #1;
    req_valid = m;
    req_addr  = a;
    if (fl_lookup) begin
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
    end
    budget = 0;
    while (done < target && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    req_valid = '0;
    if (done < target) begin
      checks++;
      errors++;
      $display("FAIL timeout: responses %0d expected %0d", done, target);
      exp_q.delete();
    end
  endtask

  task automatic flush_idle();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    mcv = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_resp_valid"}, int'(resp_valid), 0);
    chk({tag, "_resp_err"}, int'(resp_err), 0);
    chk({tag, "_lut_address"}, int'(lut_address), 0);
    chk({tag, "_resp_path"}, int'(resp_path), 0);
  endtask

  // Backpressure: hold the owner's ready low (others high) for stall_cnt response cycles.
  initial forever begin
    @(posedge clk); #1;
    if (resp_valid != 0 && stall_cnt > 0) begin
      resp_ready = ~resp_valid;
      stall_cnt--;
    end else resp_ready = '1;
  end

  // Monitor: pops expectations on grants and checks each response.
  initial begin
    exp_t cur;
    bit pend = 1'b0, act = 1'b0;
    logic [3:0] hv;
    logic [6:0] hp;
    logic he;
    cur = '{0, 0, 0, 0, 0, 1'b0};
    hv = '0; hp = '0; he = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend = 1'b0;
        act  = 1'b0;
      end else begin
        if (req_ready != 0) begin
          if (pend || act) begin
            checks++; errors++;
            $display("FAIL grant_busy: req_ready %b while a lookup is outstanding", req_ready);
          end else if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: req_ready %b expected none", req_ready);
          end else begin
            cur = exp_q.pop_front();
            chk("grant", int'(req_ready), 1 << cur.g);
            if (cur.b2b) chk("grant_gap", cyc - hcyc, 1);
            gcyc = cyc;
            pend = 1'b1;
          end
        end
        if (resp_valid != 0) begin
          if (pend) begin
            pend = 1'b0;
            act  = 1'b1;
            chk("resp_valid", int'(resp_valid), 1 << cur.g);
            chk("resp_path", int'(resp_path), cur.path);
            chk("resp_err", int'(resp_err), cur.err);
            chk("latency", cyc - gcyc, cur.lat);
            chk("lut_address", int'(lut_address), cur.addr);
            hv = resp_valid; hp = resp_path; he = resp_err;
          end else if (act) begin
            chk("hold_valid", int'(resp_valid), int'(hv));
            chk("hold_path", int'(resp_path), int'(hp));
            chk("hold_err", int'(resp_err), int'(he));
          end else begin
            checks++; errors++;
            $display("FAIL spurious_resp: resp_valid %b with no grant", resp_valid);
          end
          if (act && (resp_valid & resp_ready) != 0) begin
            act  = 1'b0;
            hcyc = cyc;
            done++;
          end
        end else if (act) begin
          checks++; errors++;
          act = 1'b0;
          $display("FAIL resp_dropped: resp_valid 0 before handshake");
        end
      end
    end
  end

  initial begin
    logic [3:0]  m;
    logic [15:0] a;
    int pick;
    for (int i = 0; i < 16; i++) tbl[i] = 7'($urandom_range(1, 127));
    tbl[3] = 7'b0000001; tbl[5] = 7'b0; tbl[9] = 7'b0011100; tbl[7] = 7'h2a; tbl[12] = 7'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(4'hf, {4'h9, 4'h5, 4'h3, 4'h3}, 5, 0, 1'b0);
    run(4'b1001, {4'h3, 4'h3, 4'h3, 4'h3}, 3, 0, 1'b0);
    flush_idle();
    run(4'b0010, {4'h0, 4'h0, 4'h3, 4'h0}, 1, 0, 1'b0);
    run(4'b0100, {4'h0, 4'h3, 4'h0, 4'h0}, 1, 0, 1'b0);
    flush_idle();
    run(4'b0100, {4'h0, 4'h3, 4'h0, 4'h0}, 1, 0, 1'b0);
    run(4'b0001, {4'h0, 4'h0, 4'h0, 4'h5}, 1, 0, 1'b0);
    run(4'b0001, {4'h0, 4'h0, 4'h0, 4'h5}, 1, 0, 1'b0);
    run(4'b0011, {4'h0, 4'h0, 4'h9, 4'h9}, 2, 5, 1'b0);
    run(4'b0001, {4'h0, 4'h0, 4'h0, 4'h7}, 1, 0, 1'b1);
    run(4'b0001, {4'h0, 4'h0, 4'h0, 4'h7}, 1, 0, 1'b0);
    run(4'b0001, {4'h0, 4'h0, 4'h0, 4'h3}, 1, 0, 1'b0);
    // Abort a miss during LOOKUP; cached route 3 must be forgotten.
    exp_q.push_back(predict(4'b0010, {4'h0, 4'h0, 4'h9, 4'h0}, 1'b0));
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_addr  = {4'h0, 4'h0, 4'h9, 4'h0};
    @(posedge clk); #1;
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midop");
    exp_q.delete();
    mrr = 0;
    mcv = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run(4'hf, {4'h3, 4'h3, 4'h3, 4'h3}, 1, 0, 1'b0);
    for (int it = 0; it < 30; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int s = 0; s < 4; s++) begin
        pick = $urandom_range(0, 3);
        a[s*4 +: 4] = (pick == 0) ? 4'h3 : (pick == 1) ? 4'h5 : (pick == 2) ? 4'h9 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) flush_idle();
      run(m, a, $urandom_range(1, 3), $urandom_range(0, 3), 1'b0);
    end
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ni_target_route_arbiter.md
# ni_target_route_arbiter

Shares one NI-target routing LUT (combinational `lut_address` → `lut_path` table) among several response packetizers inside an NI target. Requesters present a source ID. The block arbitrates round-robin, drives the LUT, registers the returned path and hands it back to the granted requester over a valid/ready handshake. A one-entry last-route cache skips the LUT cycle when the same source ID repeats. Unknown sources (LUT default path 0) are flagged as routing errors.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `SRC_W`, 4: source ID width; equals `SOURCEWD`.
- `PATH_W`, 7: route path width; equals the LUT output width.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: requester i wants a lookup.
- `req_addr` in NREQ*SRC_W: source ID of requester i, in slice [i*SRC_W +: SRC_W].
- `req_ready` out NREQ: one-hot grant pulse; the request is accepted when valid and ready are both high.
- `lut_address` out SRC_W: registered address to the routing LUT.
- `lut_path` in PATH_W: combinational LUT result for `lut_address`.
- `resp_valid` out NREQ: one-hot; the response is for requester i.
- `resp_path` out PATH_W: looked-up path, first hop in the LSBs.
- `resp_err` out 1: high with `resp_valid` when the path is 0 (unknown source).
- `resp_ready` in NREQ: requester i consumes the response.
- `flush` in 1: invalidates the route cache.

## Operation
- FSM states: IDLE, LOOKUP, RESP. Reset state is IDLE.
- **IDLE, grant:**
  - If any `req_valid` is high, grant the first valid index at or after `rr_ptr`, wrapping modulo NREQ.
  - Assert that bit of `req_ready`, capture `req_addr[g]` into `cur_addr` and `lut_address`, and record `g` in `owner`.
  - `rr_ptr` becomes (g+1) mod NREQ.
- **IDLE, next state:**
  - Cache hit (`cache_v` high and `cache_addr` == captured addr): load `resp_path` from `cache_path` and go to RESP.
  - Otherwise go to LOOKUP.
- **LOOKUP:**
  - `lut_address` is stable; register `lut_path` into `resp_path`.
  - Set `resp_err` = (lut_path == 0).
  - If the path is nonzero, write `cache_addr`/`cache_path` and set `cache_v`. Zero paths are never cached.
  - Go to RESP.
- **RESP:**
  - `resp_valid[owner]` is high; `resp_path` and `resp_err` are held stable.
  - On `resp_ready[owner]`, go to IDLE. `resp_ready` bits of other requesters are ignored.
- Only one lookup is outstanding at any time. `req_ready` is 0 outside IDLE.
- **flush:**
  - Clears `cache_v` the next cycle, in any state.
  - If it coincides with a LOOKUP cache write, flush wins and `cache_v` ends 0.
  - A hit decided in the same IDLE cycle as `flush` is still served from the cache.
- `lut_address` holds its last value outside grant cycles; it is not returned to 0.

## Timing
- Reset values:
  - `req_ready`, `resp_valid`, `resp_err`, `cache_v`: 0.
  - `lut_address`, `resp_path`, `owner`, `rr_ptr`: 0.
  - State: IDLE.
- Asynchronous reset mid-transaction aborts the transaction. No response is produced and the requester must re-request.
- `req_ready` is combinational from `req_valid`, state and `rr_ptr`. All other outputs are registers.
- Miss latency: grant in cycle T, LOOKUP at T+1, `resp_valid` at T+2.
- Hit latency: grant in cycle T, `resp_valid` at T+1.
- Handshake complete in cycle R: the next grant is possible at R+1. A miss therefore sustains at most one lookup per 3 cycles, a hit one per 2 cycles.
- Backpressure: RESP holds for any number of cycles while `resp_ready[owner]` is low.

## Test plan
- **Single miss:**
  - Stimulus: requester 1 sends addr 4'h3 with a table mapping 3 → 7'b0000001.
  - Response: `req_ready`=0010 at T, `lut_address`=3 at T+1, `resp_valid`=0010 with `resp_path`=0000001 and `resp_err`=0 at T+2.
- **Cache hit:**
  - Stimulus: after the previous test, requester 2 sends addr 3.
  - Response: `resp_valid`=0100 at T+1 with path 0000001, and `lut_address` is not re-driven through LOOKUP.
  - Then assert `flush`, repeat: latency returns to 2.
- **Unknown source:**
  - Stimulus: addr 4'h5 (unmapped).
  - Response: `resp_path`=0 and `resp_err`=1 at T+2. A repeat of addr 5 still takes the 2-cycle miss path.
- **Round-robin:**
  - Stimulus: all four `req_valid` held high from reset with `resp_ready` tied high.
  - Response: grant order 0,1,2,3,0. Then with only requesters 3 and 0 valid, the order alternates 3,0,3.
- **Backpressure:**
  - Stimulus: addr 4'h9 (path 0011100), with `resp_ready` low for 5 cycles while another requester is valid.
  - Response: `resp_valid`/`resp_path` held stable for those 5 cycles and no new `req_ready`. The next grant comes one cycle after the handshake.
- **Reset mid-op:**
  - Stimulus: assert `rst_n`=0 during LOOKUP.
  - Response: all outputs drop to reset values immediately (asynchronous), `cache_v`=0, and the first post-reset grant goes to index 0.
